// File: rtl/watch_pkg.sv
// Shared watch encodings: modes, sequencer states, special keypad codes and the
// per-digit entry limit check used by the time-setting sequencer.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_WATCH     = 2'b00,
    MODE_ALARM     = 2'b01,
    MODE_STOPWATCH = 2'b10,
    MODE_SETTING   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam logic [3:0] KEY_CANCEL = 4'hA;
  localparam logic [3:0] KEY_BKSP   = 4'hB;
  localparam int         NUM_DIGITS = 6;

  // Step 1 bound depends on the already staged hour tens digit (20-23 vs 00-19).
  function automatic logic digit_ok(input logic [2:0] step, input logic [3:0] h_ten,
                                    input logic [3:0] digit);
    logic ok;
    case (step)
      3'd0:       ok = (digit <= 4'd2);
      3'd1:       ok = (h_ten == 4'd2) ? (digit <= 4'd3) : (digit <= 4'd9);
      3'd2, 3'd4: ok = (digit <= 4'd5);
      default:    ok = (digit <= 4'd9);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability debounce, registered rise pulse.
// Press pulse appears DEB_CYC+3 cycles after the raw rising edge.
module btn_debounce #(
  parameter int DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int            CW       = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          s0, s1, deb, deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      s0    <= btn;
      s1    <= s0;
      deb_q <= deb;
      press <= deb & ~deb_q;
      // cnt tracks how long the synced level has disagreed with the accepted level
      if (s1 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Watch mode register and 6-digit keypad time-entry sequencer; emits a one-cycle
// load strobe with the validated BCD time.
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int DEB_CYC     = 20,
  parameter int TIMEOUT_CYC = 10000,
  parameter int BLINK_HALF  = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_btn,
  input  logic        setting_btn,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [23:0] cur_time,
  output logic [1:0]  mode,
  output logic        set_active,
  output logic [2:0]  edit_step,
  output logic [5:0]  blink_mask,
  output logic        load_en,
  output logic [23:0] load_time,
  output logic        key_err
);
  localparam int            TW      = $clog2(TIMEOUT_CYC);
  localparam int            BW      = $clog2(BLINK_HALF);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);

  logic mode_press, set_press;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_mode_deb (
    .clk(clk), .rst(rst), .btn(mode_btn), .press(mode_press));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_set_deb (
    .clk(clk), .rst(rst), .btn(setting_btn), .press(set_press));

  state_e        state_q, state_n;
  mode_e         mode_q, mode_n;
  logic [23:0]   stg_q, stg_n, load_time_n;
  logic [TW-1:0] to_q, to_n;
  logic [BW-1:0] bcnt_q, bcnt_n;
  logic          ph_q, ph_n;
  logic [2:0]    step_n;
  logic [5:0]    blink_n;
  logic          set_act_n, load_en_n, key_err_n, abort, is_digit;

  assign mode = mode_q;

  always_comb begin
    state_n     = state_q;
    mode_n      = mode_q;
    step_n      = edit_step;
    stg_n       = stg_q;
    to_n        = '0;
    bcnt_n      = '0;
    ph_n        = 1'b1;
    load_en_n   = 1'b0;
    load_time_n = load_time;
    key_err_n   = 1'b0;
    abort       = 1'b0;
    is_digit    = (key_code <= 4'd9);
    case (state_q)
      ST_RUN: begin
        if (set_press) begin
          stg_n   = cur_time;
          step_n  = 3'd0;
          mode_n  = MODE_SETTING;
          state_n = ST_EDIT;
        end else if (mode_press) begin
          case (mode_q)
            MODE_WATCH: mode_n = MODE_ALARM;
            MODE_ALARM: mode_n = MODE_STOPWATCH;
            default:    mode_n = MODE_WATCH;
          endcase
        end
      end
      ST_EDIT: begin
        to_n = to_q + TW'(1);
        if (bcnt_q == BL_LAST) begin
          bcnt_n = '0;
          ph_n   = ~ph_q;
        end else begin
          bcnt_n = bcnt_q + BW'(1);
          ph_n   = ph_q;
        end
        // Priority: abort request, then a key (which also beats timeout expiry)
        if (set_press || (key_valid && key_code == KEY_CANCEL)) begin
          abort = 1'b1;
        end else if (key_valid && is_digit) begin
          to_n = '0;
          if (digit_ok(edit_step, stg_q[23:20], key_code)) begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (edit_step == 3'(i)) stg_n[(5-i)*4 +: 4] = key_code;
            bcnt_n = '0;
            ph_n   = 1'b1;
            if (edit_step == 3'd5) begin
              state_n = ST_COMMIT;
              step_n  = 3'd0;
            end else begin
              step_n = edit_step + 3'd1;
            end
          end else begin
            key_err_n = 1'b1;
          end
        end else if (key_valid && key_code == KEY_BKSP) begin
          to_n = '0;
          if (edit_step != 3'd0) step_n = edit_step - 3'd1;
        end else if (to_q == TO_LAST) begin
          abort = 1'b1;
        end
        if (abort) begin
          state_n = ST_RUN;
          mode_n  = MODE_WATCH;
          step_n  = 3'd0;
        end
      end
      ST_COMMIT: begin
        load_en_n   = 1'b1;
        load_time_n = stg_q;
        mode_n      = MODE_WATCH;
        state_n     = ST_RUN;
      end
      default: state_n = ST_RUN;
    endcase
    set_act_n = (state_n == ST_EDIT);
    blink_n   = '0;
    if (set_act_n)
      for (int i = 0; i < NUM_DIGITS; i++)
        if (step_n == 3'(i)) blink_n[5-i] = ph_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      mode_q     <= MODE_WATCH;
      stg_q      <= '0;
      to_q       <= '0;
      bcnt_q     <= '0;
      ph_q       <= 1'b1;
      set_active <= 1'b0;
      edit_step  <= '0;
      blink_mask <= '0;
      load_en    <= 1'b0;
      load_time  <= '0;
      key_err    <= 1'b0;
    end else begin
      state_q    <= state_n;
      mode_q     <= mode_n;
      stg_q      <= stg_n;
      to_q       <= to_n;
      bcnt_q     <= bcnt_n;
      ph_q       <= ph_n;
      set_active <= set_act_n;
      edit_step  <= step_n;
      blink_mask <= blink_n;
      load_en    <= load_en_n;
      load_time  <= load_time_n;
      key_err    <= key_err_n;
    end
  end

endmodule
